// File: rtl/delay_config_controller.sv
// delay_config_controller: serial MCU config of beamformer delay taps with frame-synchronous shadow-to-active commit
module delay_config_controller #(
  parameter int NUM_DELAYS  = 6,
  parameter int BUFFER_SIZE = 8,
  parameter int IDX_W       = $clog2(BUFFER_SIZE),
  parameter int SEL_W       = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ws,
  input  logic                        cfg_start,
  input  logic                        cfg_valid,
  input  logic                        cfg_bit,
  output logic [NUM_DELAYS*IDX_W-1:0] delay_flat,
  output logic                        cfg_ready,
  output logic                        commit_pending,
  output logic                        apply_pulse,
  output logic                        cfg_error
);
  localparam int W  = SEL_W + IDX_W;
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, EXEC = 2'd2, WAIT_FRAME = 2'd3;
  localparam logic [SEL_W-1:0] SEL_COMMIT = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] SEL_CLEAR  = SEL_COMMIT - 1'b1;

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [W-1:0]                sr_q, sr_d;
  logic [NUM_DELAYS*IDX_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                        ws_q, pend_q, pend_d, apply_q, apply_d, err_q, err_d;
  logic [SEL_W-1:0]            sel;
  logic [IDX_W-1:0]            idx;
  logic                        fall;

  assign sel  = sr_q[W-1 -: SEL_W];
  assign idx  = sr_q[IDX_W-1:0];
  assign fall = ws_q & ~ws;

  // next-state: receive word, decode it for one cycle, or hold a commit until the ws falling edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    apply_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: if (cfg_start) begin
        state_d = SHIFT;
        cnt_d   = '0;
        sr_d    = '0;
      end
      SHIFT: if (cfg_start) begin
        cnt_d = '0;
        sr_d  = '0;
      end else if (cfg_valid) begin
        sr_d    = {sr_q[W-2:0], cfg_bit};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W - 1)) ? EXEC : SHIFT;
      end
      EXEC: begin
        state_d = IDLE;
        if (sel == SEL_COMMIT) begin
          state_d = WAIT_FRAME;
          pend_d  = 1'b1;
        end else if (sel == SEL_CLEAR) shadow_d = '0;
        else if (32'(sel) < NUM_DELAYS) shadow_d[32'(sel)*IDX_W +: IDX_W] = idx;
        else err_d = 1'b1;
      end
      default: if (fall) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
        apply_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // state registers; reset discards any pending commit and zeroes both banks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ws_q     <= 1'b0;
      pend_q   <= 1'b0;
      apply_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ws_q     <= ws;
      pend_q   <= pend_d;
      apply_q  <= apply_d;
      err_q    <= err_d;
    end
  end

  assign delay_flat     = active_q;
  assign cfg_ready      = state_q == IDLE;
  assign commit_pending = pend_q;
  assign apply_pulse    = apply_q;
  assign cfg_error      = err_q;
endmodule

// File: tb/tb_delay_config_controller.sv
// tb_delay_config_controller: table, directed and random checks against a word-level reference model
module tb_delay_config_controller;
  logic clk = 0, reset = 1, ws = 0, cfg_start = 0, cfg_valid = 0, cfg_bit = 0;
  logic [17:0] delay_flat;
  logic cfg_ready, commit_pending, apply_pulse, cfg_error;
  logic [14:0] flat5;
  logic ready5, pend5, apply5, err5;
  int tests = 0, fails = 0;
  bit chk_en = 0;

  typedef struct {int sel; int idx; int exp_flat; int exp_err5;} vec_t;
  vec_t tbl[9];

  bit m_rx, m_exec, m_wait, m_prev, m_apply, m_err5;
  bit m_bits[$];
  int m_word;
  int m_shadow[6], m_active[6];

  always #5 clk = ~clk;

  delay_config_controller dut (
    .clk(clk), .reset(reset), .ws(ws), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .delay_flat(delay_flat), .cfg_ready(cfg_ready), .commit_pending(commit_pending),
    .apply_pulse(apply_pulse), .cfg_error(cfg_error)
  );

  delay_config_controller #(.NUM_DELAYS(5)) dut5 (
    .clk(clk), .reset(reset), .ws(ws), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .delay_flat(flat5), .cfg_ready(ready5), .commit_pending(pend5),
    .apply_pulse(apply5), .cfg_error(err5)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_flat();
    int s = 0;
    for (int k = 0; k < 6; k++) s += m_active[k] << (3 * k);
    return s;
  endfunction

  task automatic model_step();
    bit nx_apply = 0;
    if (reset) begin
      m_rx = 0; m_exec = 0; m_wait = 0; m_prev = 0; m_apply = 0; m_err5 = 0;
      m_bits.delete();
      for (int k = 0; k < 6; k++) begin m_shadow[k] = 0; m_active[k] = 0; end
      return;
    end
    if (m_wait) begin
      if (m_prev && !ws) begin
        m_active = m_shadow;
        m_wait = 0;
        nx_apply = 1;
      end
    end else if (m_exec) begin
      int sel = m_word / 8, idx = m_word % 8;
      m_exec = 0;
      if (sel < 6) m_shadow[sel] = idx;
      else if (sel == 6) for (int k = 0; k < 6; k++) m_shadow[k] = 0;
      else m_wait = 1;
      if (sel == 5) m_err5 = 1;
    end else if (cfg_start) begin
      m_rx = 1;
      m_bits.delete();
    end else if (m_rx && cfg_valid) begin
      m_bits.push_back(cfg_bit);
      if (m_bits.size() == 6) begin
        m_word = 0;
        foreach (m_bits[i]) m_word = m_word * 2 + int'(m_bits[i]);
        m_rx = 0;
        m_exec = 1;
      end
    end
    m_prev = ws;
    m_apply = nx_apply;
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
    if (chk_en) begin
      chk("model_flat", int'(delay_flat), m_flat());
      chk("model_ready", int'(cfg_ready), int'(!m_rx && !m_exec && !m_wait));
      chk("model_pending", int'(commit_pending), int'(m_wait));
      chk("model_apply", int'(apply_pulse), int'(m_apply));
      chk("model_error", int'(cfg_error), 0);
      chk("model_error5", int'(err5), int'(m_err5));
    end
  end

  task automatic drive(input bit s, input bit v, input bit b);
    cfg_start = s; cfg_valid = v; cfg_bit = b;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int sel, input int idx, input bit gap);
    logic [5:0] w;
    w = 6'(sel * 8 + idx);
    drive(1, 1'($urandom), 1'($urandom));
    for (int i = 5; i >= 0; i--) begin
      if (gap) drive(0, 0, 1'($urandom));
      drive(0, 1, w[i]);
    end
    drive(0, 0, 0);
  endtask

  initial begin
    tbl[0] = '{0, 1, 327, 0};
    tbl[1] = '{1, 2, 327, 0};
    tbl[2] = '{2, 3, 327, 0};
    tbl[3] = '{3, 4, 327, 0};
    tbl[4] = '{4, 5, 327, 0};
    tbl[5] = '{5, 6, 327, 1};
    tbl[6] = '{7, 0, 219345, 1};
    tbl[7] = '{6, 0, 219345, 1};
    tbl[8] = '{7, 0, 0, 1};

    reset = 1;
    drive(1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_flat", int'(delay_flat), 0);
    chk("reset_ready", int'(cfg_ready), 1);
    chk("reset_pending", int'(commit_pending), 0);
    chk("reset_apply", int'(apply_pulse), 0);
    chk("reset_error", int'(cfg_error), 0);
    reset = 0;
    chk_en = 1;

    ws = 1;
    send(2, 5, 0);
    chk("write_flat_unchanged", int'(delay_flat), 0);
    chk("write_ready", int'(cfg_ready), 1);
    send(7, 0, 0);
    chk("commit_pending_set", int'(commit_pending), 1);
    ws = 0;
    drive(0, 0, 0);
    chk("commit_flat", int'(delay_flat), 5 << 6);
    chk("commit_apply", int'(apply_pulse), 1);
    chk("commit_pending_clr", int'(commit_pending), 0);
    drive(0, 0, 0);
    chk("apply_one_cycle", int'(apply_pulse), 0);

    ws = 1;
    send(0, 3, 0);
    send(7, 0, 0);
    for (int i = 0; i < 20; i++) drive(i % 4 == 0, 1, 1);
    chk("gate_flat_held", int'(delay_flat), 320);
    chk("gate_pending", int'(commit_pending), 1);
    chk("gate_not_ready", int'(cfg_ready), 0);
    ws = 0;
    drive(0, 0, 0);
    chk("gate_flat_applied", int'(delay_flat), 323);

    ws = 1;
    drive(1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1'($urandom));
    send(0, 7, 1);
    send(7, 0, 0);
    ws = 0;
    drive(0, 0, 0);
    chk("restart_tap0", int'(delay_flat[2:0]), 7);

    foreach (tbl[i]) begin
      ws = 1;
      drive(0, 0, 0);
      send(tbl[i].sel, tbl[i].idx, 0);
      if (tbl[i].sel == 7) begin
        ws = 0;
        drive(0, 0, 0);
      end
      chk($sformatf("tbl%0d_flat", i), int'(delay_flat), tbl[i].exp_flat);
      chk($sformatf("tbl%0d_err5", i), int'(err5), tbl[i].exp_err5);
      chk($sformatf("tbl%0d_err6", i), int'(cfg_error), 0);
    end

    ws = 1;
    send(1, 4, 0);
    send(7, 0, 0);
    chk("rst_wait_pending", int'(commit_pending), 1);
    reset = 1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    reset = 0;
    ws = 0;
    drive(0, 0, 0);
    ws = 1;
    drive(0, 0, 0);
    ws = 0;
    drive(0, 0, 0);
    chk("rst_wait_flat", int'(delay_flat), 0);
    chk("rst_wait_pending_clr", int'(commit_pending), 0);
    chk("rst_wait_err5_clr", int'(err5), 0);

    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 5) == 0) ws = ~ws;
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
